// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline constants and writeback entry type
package mips_pipe_pkg;
    localparam int NREG    = 32;
    localparam int ALU_LAT = 3;
    localparam int LD_LAT  = 4;
    localparam int CNT_W   = 3;
    localparam int AW      = 5;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
    } wb_entry_t;
endpackage

// File: rtl/wb_slot_queue.sv
// rtl/wb_slot_queue.sv - writeback port reservation shift queue
module wb_slot_queue
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH = LD_LAT,
    parameter int IW    = CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            ins_en,
    input  logic [IW-1:0]   ins_idx,
    input  wb_entry_t       ins_entry,
    output logic [DEPTH:1]  slot_valid,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_addr
);

    wb_entry_t q [1:DEPTH];

    // Entries move toward index 1; an insert overrides the shifted value at its index.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 1; k <= DEPTH; k++) begin
                q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                q[k] <= (ins_en && ins_idx == IW'(k)) ? ins_entry : q[k+1];
            end
            q[DEPTH] <= (ins_en && ins_idx == IW'(DEPTH)) ? ins_entry : '0;
        end
    end

    always_comb begin
        slot_valid = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            slot_valid[k] = q[k].valid;
        end
    end

    assign wb_valid = q[1].valid;
    assign wb_addr  = q[1].valid ? q[1].addr : '0;

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// rtl/reg_hazard_scoreboard.sv - issue-stage RAW/WAW/write-port interlock
module reg_hazard_scoreboard
    import mips_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            is_load,
    input  logic [AW-1:0]   add_A,
    input  logic [AW-1:0]   add_B,
    input  logic [AW-1:0]   add_mem,
    input  logic            dst_we,
    input  logic [AW-1:0]   dst_addr,
    input  logic            flush,
    output logic            stall,
    output logic            issue_fire,
    output logic [NREG-1:0] busy_mask,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_addr
);

    logic [CNT_W-1:0] cnt [1:NREG-1];
    logic [CNT_W-1:0] lat;
    logic [LD_LAT:1]  slot_valid;
    logic             raw, waw, slot, track;
    wb_entry_t        ins_entry;
    logic             unused_slot1;

    assign lat = is_load ? CNT_W'(LD_LAT) : CNT_W'(ALU_LAT);

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    // The entry at lat+1 shifts into lat next edge, colliding with the new instruction.
    always_comb begin
        slot = 1'b0;
        for (int k = 1; k < LD_LAT; k++) begin
            if (lat == CNT_W'(k) && slot_valid[k+1]) begin
                slot = 1'b1;
            end
        end
    end

    assign raw        = busy_mask[add_A] | busy_mask[add_B] | busy_mask[add_mem];
    assign waw        = dst_we & busy_mask[dst_addr];
    assign stall      = issue_valid & (raw | waw | slot);
    assign issue_fire = issue_valid & ~stall & ~flush;
    assign track      = issue_fire & dst_we & (dst_addr != '0);
    assign ins_entry  = '{valid: 1'b1, addr: dst_addr};
    assign unused_slot1 = slot_valid[1];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int r = 1; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (track && dst_addr == AW'(r)) begin
                    cnt[r] <= lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    wb_slot_queue #(
        .DEPTH (LD_LAT),
        .IW    (CNT_W)
    ) u_wbq (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .ins_en     (track),
        .ins_idx    (lat),
        .ins_entry  (ins_entry),
        .slot_valid (slot_valid),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr)
    );

endmodule

// File: doc/reg_hazard_scoreboard.md
Name: reg_hazard_scoreboard

Overview:
- Issue-stage interlock controller for the in-order MIPS pipeline. Sits directly after the register-address decoder.
- Consumes the decoded source addresses (A, B, store-data) and the destination of the instruction being issued. Tracks outstanding register writes with per-register countdowns.
- Asserts stall on RAW, WAW and writeback-port conflicts, and sequences the single register-file write port by emitting the predicted writeback address each cycle.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- ALU_LAT, 3, cycles from issue to writeback for non-load instructions.
- LD_LAT, 4, cycles from issue to writeback for lw; must satisfy LD_LAT >= ALU_LAT >= 1.
- CNT_W, 3, countdown width; must hold LD_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  an instruction is presented for issue this cycle.
- is_load  in  1  the presented instruction uses LD_LAT; otherwise it uses ALU_LAT.
- add_A  in  5  source A register; 0 means unused.
- add_B  in  5  source B register; 0 means unused.
- add_mem  in  5  store-data source register; 0 means unused.
- dst_we  in  1  the presented instruction writes a register.
- dst_addr  in  5  destination register.
- flush  in  1  branch/jump redirect; kill all tracked writes.
- stall  out  1  hold the presented instruction (combinational).
- issue_fire  out  1  the instruction is accepted this cycle (combinational).
- busy_mask  out  NREG  bit r set while register r has a pending write (registered).
- wb_valid  out  1  register-file write port is used this cycle (registered).
- wb_addr  out  5  register written this cycle; 0 when wb_valid=0.

Behaviour:
- Reset: on rst=1 at a clk edge, all countdowns and writeback-queue entries clear. busy_mask=0, wb_valid=0, wb_addr=0. Reset mid-operation discards all pending writes and produces no writeback.
- State, countdowns: cnt[r] for r = 1..NREG-1. busy(r) = (cnt[r] != 0). busy(0) is always 0.
- State, writeback queue: wbq[1..LD_LAT]. Each entry holds {valid, addr}.
- Latency select: L = is_load ? LD_LAT : ALU_LAT.
- Hazard terms:
  - raw = busy(add_A) | busy(add_B) | busy(add_mem).
  - waw = dst_we & busy(dst_addr).
  - slot = (L < LD_LAT) & wbq[L+1].valid. That entry shifts into index L on the next edge, so the new instruction would collide on the write port.
- stall = issue_valid & (raw | waw | slot). The flush input does not affect stall.
- issue_fire = issue_valid & ~stall & ~flush.
- Each edge when not in rst or flush:
  - Every nonzero cnt decrements by 1.
  - wbq shifts: index k moves to k-1, and index 1 is dropped.
  - On issue_fire with dst_we=1 and dst_addr != 0: cnt[dst_addr] <= L and wbq[L] <= {1, dst_addr}, overriding the shift at that index.
  - An issue with dst_addr=0 or dst_we=0 tracks nothing and consumes no write slot.
- Output timing:
  - wb_valid/wb_addr present wbq[1] each cycle.
  - The cycle after issue, cnt=L and the entry sits at index L. In the writeback cycle, cnt=1 and the entry is at index 1.
  - The register is still busy during its writeback cycle and becomes free on the following cycle. There is no bypass.
- Fixed single-instruction latency: issue at cycle t gives wb_valid at cycle t+L and busy clear at t+L+1.
- flush: at the next edge, all cnt and wbq entries clear. issue_fire=0 during a flush cycle. A flush in the same cycle as rst behaves as rst.
- Simultaneous events:
  - A decrement to 0 and a new set of the same register cannot coincide, because waw stalls that case.
  - busy_mask is derived from the registered cnt values, so it updates one edge after the event.
- Sources equal to 0 never stall. The decoder zeroes unused fields, and the scoreboard relies on that.

Decomposition:
- Shared package mips_pipe_pkg: ALU_LAT, LD_LAT, NREG, the register-address width (5), and a wb_entry typedef {valid, addr}.
- One sub-module: wb_slot_queue. It holds the LD_LAT-deep shift queue with an insert-at-index port, exposes the per-index valid bits for the slot check, and drives wb_valid/wb_addr.

Test Plan:
1. Basic write tracking: rst, then issue ALU dst=5 at cycle 0. Expect busy_mask[5]=1 in cycles 1-3, wb_valid=1 with wb_addr=5 at cycle 3, and busy_mask[5]=0 at cycle 4.
2. RAW stall: issue lw dst=8, then hold an instruction with add_A=8. Expect stall=1 in cycles 1-4 and issue_fire=1 at cycle 5.
3. Write-port conflict: issue lw dst=2 at cycle 0, then ALU dst=3 at cycle 1 with no RAW. Expect slot stall at cycle 1 and fire at cycle 2. Then expect wb_addr=2 at cycle 4 and wb_addr=3 at cycle 5, with no cycle where both write.
4. WAW stall: issue ALU dst=9, then present dst_we=1 with dst=9. Expect stall in cycles 1-3 and fire at cycle 4.
5. Register zero: issue ALU dst=0, then add_A=0. Expect no stall, busy_mask=0 and wb_valid never 1.
6. Flush and reset: issue lw dst=4, assert flush at cycle 2. Expect busy_mask=0 and wb_valid=0 from cycle 3 onward. Repeat with rst at cycle 2 and expect the same result.
